adder_neuron_scheduler: RTL and testbench

//  Clocked sequencer behind the adder-node depacketizer of the SNN NoC.
//  - Inputs: per-neuron 8-bit partial sums from PE0/PE1/PE2 and 8-bit membrane bytes from memory.
//  - Pairs one value per channel for the current neuron, in any arrival order.
//  - Integrates them, compares against the firing threshold, and emits spike plus new membrane potential.
//  - Counts neurons per timestep and timesteps per run.

---
 rtl/adder_neuron_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_adder_neuron_scheduler.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_neuron_scheduler.sv
// adder_neuron_scheduler
// Collects one membrane byte and three PE partial sums for the current neuron,
// in any arrival order. It integrates them and compares the sum against the
// firing threshold. It then presents spike plus the new membrane potential to
// the packetizer, and counts neurons per timestep and timesteps per run.
module adder_neuron_scheduler #(
    parameter int WIDTH        = 8,
    parameter int NUM_NEURON   = 3,
    parameter int NUM_TIMESTEP = 10,
    parameter int THRESHOLD    = 64,
    localparam int IDX_W = (NUM_NEURON   > 1) ? $clog2(NUM_NEURON)   : 1,
    localparam int TS_W  = (NUM_TIMESTEP > 1) ? $clog2(NUM_TIMESTEP) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pe0_valid,
    output logic             pe0_ready,
    input  logic [WIDTH-1:0] pe0_data,
    input  logic             pe1_valid,
    output logic             pe1_ready,
    input  logic [WIDTH-1:0] pe1_data,
    input  logic             pe2_valid,
    output logic             pe2_ready,
    input  logic [WIDTH-1:0] pe2_data,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [WIDTH-1:0] mem_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_spike,
    output logic [WIDTH-1:0] out_mem,
    output logic [IDX_W-1:0] out_idx,
    output logic [TS_W-1:0]  timestep,
    output logic             ts_done,
    output logic             busy,
    output logic             done
);

    localparam int NCH   = 4;          // pe0, pe1, pe2, mem
    localparam int SUM_W = WIDTH + 2;  // four WIDTH-bit operands never overflow this
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURON - 1);
    localparam logic [TS_W-1:0]  LAST_TS  = TS_W'(NUM_TIMESTEP - 1);
    localparam logic [SUM_W-1:0] THRESH   = SUM_W'(THRESHOLD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_COMPUTE,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic             spike_q, spike_d;
    logic [WIDTH-1:0] mem_out_q, mem_out_d;
    logic             ts_done_q, ts_done_d;

    logic             collecting;
    logic             retire;
    logic             all_full_next;
    logic [NCH-1:0]   ch_valid;
    logic [NCH-1:0]   full_vec;
    logic [NCH-1:0]   accept_vec;
    logic [WIDTH-1:0] ch_data  [NCH];
    logic [WIDTH-1:0] hold_vec [NCH];
    logic [SUM_W-1:0] sum;

    assign collecting = (state_q == S_COLLECT);

    // Channel order is fixed: 0=pe0, 1=pe1, 2=pe2, 3=mem.
    assign ch_valid   = {mem_valid, pe2_valid, pe1_valid, pe0_valid};
    assign ch_data[0] = pe0_data;
    assign ch_data[1] = pe1_data;
    assign ch_data[2] = pe2_data;
    assign ch_data[3] = mem_data;

    // One hold register and full flag per channel. A channel accepts at most
    // one value per neuron and then stalls until the result is retired.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic             full_q, full_d;
            logic [WIDTH-1:0] hold_q, hold_d;

            assign accept_vec[gi] = collecting && ch_valid[gi] && !full_q;

            // Load on accept; empty the slot when the neuron retires.
            always_comb begin
                full_d = full_q;
                hold_d = hold_q;
                if (retire) begin
                    full_d = 1'b0;
                end else if (accept_vec[gi]) begin
                    full_d = 1'b1;
                    hold_d = ch_data[gi];
                end
            end

            // Hold register and flag state.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    full_q <= 1'b0;
                    hold_q <= '0;
                end else begin
                    full_q <= full_d;
                    hold_q <= hold_d;
                end
            end

            assign full_vec[gi] = full_q;
            assign hold_vec[gi] = hold_q;
        end
    endgenerate

    // The neuron is complete once every slot is either already full or filling on this edge.
    assign all_full_next = &(full_vec | accept_vec);

    assign sum = SUM_W'(hold_vec[0]) + SUM_W'(hold_vec[1])
               + SUM_W'(hold_vec[2]) + SUM_W'(hold_vec[3]);

    // Next-state, counter and result logic for the neuron sequencer.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ts_d      = ts_q;
        spike_d   = spike_q;
        mem_out_d = mem_out_q;
        ts_done_d = 1'b0;
        retire    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_COLLECT;
                    idx_d   = '0;
                    ts_d    = '0;
                end
            end
            S_COLLECT: begin
                if (all_full_next) begin
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                // A firing neuron resets to zero. Otherwise the sum is below
                // the threshold, so it fits in WIDTH bits.
                if (sum >= THRESH) begin
                    spike_d   = 1'b1;
                    mem_out_d = '0;
                end else begin
                    spike_d   = 1'b0;
                    mem_out_d = sum[WIDTH-1:0];
                end
                state_d = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    retire = 1'b1;
                    if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_COLLECT;
                    end else begin
                        idx_d     = '0;
                        ts_done_d = 1'b1;
                        if (ts_q != LAST_TS) begin
                            ts_d    = ts_q + 1'b1;
                            state_d = S_COLLECT;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state, counters and registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            ts_q      <= '0;
            spike_q   <= 1'b0;
            mem_out_q <= '0;
            ts_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ts_q      <= ts_d;
            spike_q   <= spike_d;
            mem_out_q <= mem_out_d;
            ts_done_q <= ts_done_d;
        end
    end

    assign pe0_ready = collecting && !full_vec[0];
    assign pe1_ready = collecting && !full_vec[1];
    assign pe2_ready = collecting && !full_vec[2];
    assign mem_ready = collecting && !full_vec[3];

    assign out_valid = (state_q == S_OUTPUT);
    assign out_spike = spike_q;
    assign out_mem   = mem_out_q;
    assign out_idx   = idx_q;
    assign timestep  = ts_q;
    assign ts_done   = ts_done_q;
    assign busy      = (state_q == S_COLLECT) || (state_q == S_COMPUTE) || (state_q == S_OUTPUT);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_adder_neuron_scheduler.sv
// Bench for adder_neuron_scheduler. The bench runs four channel drivers that
// feed per-channel value queues. A reference model predicts each neuron's
// result from the n-th value of every channel. A single compare process
// checks the outputs on every falling edge.
module tb_adder_neuron_scheduler;

    localparam int W     = 8;
    localparam int NN    = 3;
    localparam int NT    = 10;
    localparam int TH    = 64;
    localparam int IDX_W = 2;
    localparam int TS_W  = 4;

    typedef struct {
        logic [7:0] v;
        int         gap;
    } ent_t;

    typedef struct {
        logic       spike;
        logic [7:0] mem;
        int         idx;
        int         ts;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             out_rdy = 1'b1;
    logic [3:0]       v_valid = 4'b0;
    logic [W-1:0]     v_data [4];
    logic [3:0]       v_ready;
    logic             out_valid, out_spike, ts_done, busy, done;
    logic [W-1:0]     out_mem;
    logic [IDX_W-1:0] out_idx;
    logic [TS_W-1:0]  timestep;

    // Channel index: 0=pe0, 1=pe1, 2=pe2, 3=mem
    ent_t q0[$], q1[$], q2[$], q3[$];
    exp_t expq[$];
    int   acc [4];
    int   r = 0, rr_run = 0, push_n = 0, cyc = 0, tsd_cnt = 0;
    int   exp_ts = 0;
    bit   exp_tsd = 0, run_active = 0, done_m = 0, chk_en = 0;
    bit   prev_complete = 0, complete = 0, exp_valid = 0;
    int   complete_cyc = 0;
    int   n_tests = 0, n_fail = 0;

    adder_neuron_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pe0_valid (v_valid[0]),
        .pe0_ready (v_ready[0]),
        .pe0_data  (v_data[0]),
        .pe1_valid (v_valid[1]),
        .pe1_ready (v_ready[1]),
        .pe1_data  (v_data[1]),
        .pe2_valid (v_valid[2]),
        .pe2_ready (v_ready[2]),
        .pe2_data  (v_data[2]),
        .mem_valid (v_valid[3]),
        .mem_ready (v_ready[3]),
        .mem_data  (v_data[3]),
        .out_valid (out_valid),
        .out_ready (out_rdy),
        .out_spike (out_spike),
        .out_mem   (out_mem),
        .out_idx   (out_idx),
        .timestep  (timestep),
        .ts_done   (ts_done),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: integrate, then fire-and-reset or keep the sum.
    function automatic logic [8:0] model(input int m, input int a, input int b, input int c);
        int s;
        s = m + a + b + c;
        if (s >= TH) return 9'h100;
        return {1'b0, s[7:0]};
    endfunction

    task automatic push_ch(input int c, input int v, input int gap);
        ent_t e;
        e.v   = 8'(v);
        e.gap = gap;
        case (c)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int c);
        case (c)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    task automatic pop_ch(input int c, output ent_t e);
        case (c)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            2: e = q2.pop_front();
            default: e = q3.pop_front();
        endcase
    endtask

    task automatic push_neuron(input int m, input int a, input int b, input int c,
                               input int gm, input int ga, input int gb, input int gc);
        exp_t e;
        logic [8:0] res;
        res     = model(m, a, b, c);
        e.spike = res[8];
        e.mem   = res[7:0];
        e.idx   = push_n % NN;
        e.ts    = push_n / NN;
        push_n++;
        expq.push_back(e);
        push_ch(0, a, ga);
        push_ch(1, b, gb);
        push_ch(2, c, gc);
        push_ch(3, m, gm);
    endtask

    // One producer per channel: present the next queued value, hold it until accepted.
    task automatic chan_proc(input int c);
        ent_t e;
        int   waited;
        bit   got, rdy;
        @(posedge clk);
        #1;
        forever begin
            while (qsize(c) == 0) begin
                @(posedge clk);
                #1;
            end
            pop_ch(c, e);
            repeat (e.gap) begin
                @(posedge clk);
                #1;
            end
            v_valid[c] = 1'b1;
            v_data[c]  = e.v;
            waited = 0;
            got    = 0;
            while (!got) begin
                @(negedge clk);
                rdy = v_ready[c];
                @(posedge clk);
                if (rdy) got = 1;
                else begin
                    waited++;
                    if (waited > 300) begin
                        $display("FAIL chan%0d_handshake: got no ready, expected ready within 300 cycles", c);
                        $fatal(1);
                    end
                end
            end
            #1;
            v_valid[c] = 1'b0;
            acc[c]++;
        end
    endtask

    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        run_active = 1;
        done_m     = 0;
        rr_run     = 0;
        exp_ts     = 0;
    endtask

    task automatic wait_valid(input string name);
        bit ok;
        ok = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        check(name, int'(ok), 1);
    endtask

    // Compare process: every falling edge, the outputs against the model.
    initial begin : cmp_proc
        exp_t it;
        forever begin
            @(negedge clk);
            cyc++;
            if (ts_done) tsd_cnt++;
            if (!chk_en) begin
                prev_complete = 0;
            end else begin
                complete = (acc[0] > r) && (acc[1] > r) && (acc[2] > r) && (acc[3] > r);
                if (complete && !prev_complete) complete_cyc = cyc;
                prev_complete = complete;
                // The result appears one cycle after the last operand lands.
                exp_valid = complete && (cyc > complete_cyc);
                check("out_valid", int'(out_valid), int'(exp_valid));
                if (exp_valid) begin
                    if (expq.size() == 0) begin
                        check("expq_nonempty", 0, 1);
                    end else begin
                        it = expq[0];
                        check("out_spike", int'(out_spike), int'(it.spike));
                        check("out_mem", int'(out_mem), int'(it.mem));
                        check("out_idx", int'(out_idx), it.idx);
                        check("out_ts", int'(timestep), it.ts);
                    end
                end
                for (int c = 0; c < 4; c++) begin
                    check($sformatf("ready%0d", c), int'(v_ready[c]),
                          int'(run_active && (acc[c] == r)));
                end
                check("busy", int'(busy), int'(run_active));
                check("done", int'(done), int'(done_m));
                check("timestep", int'(timestep), exp_ts);
                check("ts_done", int'(ts_done), int'(exp_tsd));
                exp_tsd = 0;
                if (exp_valid && out_rdy && expq.size() != 0) begin
                    it = expq.pop_front();
                    $display("[TB] neuron ts=%0d idx=%0d spike=%0b mem=%0d", it.ts, it.idx, it.spike, it.mem);
                    r++;
                    rr_run++;
                    exp_tsd = (it.idx == NN - 1);
                    if (rr_run == NN * NT) begin
                        run_active = 0;
                        done_m     = 1;
                    end
                    exp_ts = (rr_run / NN >= NT) ? NT - 1 : rr_run / NN;
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got no finish, expected finish before 300us");
        $fatal(1);
    end

    initial begin : main
        bit ok;
        for (int c = 0; c < 4; c++) begin
            acc[c]    = 0;
            v_data[c] = '0;
        end
        fork
            chan_proc(0);
            chan_proc(1);
            chan_proc(2);
            chan_proc(3);
        join_none

        // Pin the reference model with hand-computed values.
        check("pin_model_50", int'(model(10, 20, 15, 5)), 50);
        check("pin_model_64", int'(model(30, 20, 10, 4)), 256);
        check("pin_model_1020", int'(model(255, 255, 255, 255)), 256);
        check("pin_model_63", int'(model(63, 0, 0, 0)), 63);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_ready", int'(v_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_timestep", int'(timestep), 0);
        check("rst_out_mem", int'(out_mem), 0);
        rst_n  = 1'b1;
        chk_en = 1;

        // Test 1: operands presented in IDLE must wait for start.
        push_n = 0;
        push_neuron(10, 20, 15, 5, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        do_start();
        wait_valid("t1_valid");
        check("t1_spike", int'(out_spike), 0);
        check("t1_mem", int'(out_mem), 50);
        check("t1_idx", int'(out_idx), 0);

        // Test 2: sum exactly at threshold
        push_neuron(30, 20, 10, 4, 1, 0, 2, 1);
        wait_valid("t2_valid");
        check("t2_spike", int'(out_spike), 1);
        check("t2_mem", int'(out_mem), 0);

        // Test 3: all four maximal operands accepted on one edge
        push_neuron(255, 255, 255, 255, 0, 0, 0, 0);
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (acc[0] > r && acc[1] > r && acc[2] > r && acc[3] > r) begin
                ok = 1;
                break;
            end
        end
        check("t3_all_accepted", int'(ok), 1);
        check("t3_valid_edge1", int'(out_valid), 0);
        @(negedge clk);
        check("t3_valid_edge2", int'(out_valid), 1);
        check("t3_spike", int'(out_spike), 1);
        check("t3_mem", int'(out_mem), 0);

        // Test 4: arrival order p2, p1, mem, p0; p2 offers 99 early for the next neuron.
        push_neuron(12, 40, 3, 7, 2, 3, 1, 0);
        push_neuron(1, 0, 0, 99, 0, 0, 0, 0);
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (v_valid[2] && v_data[2] == 8'd99) begin
                ok = 1;
                break;
            end
        end
        check("t4_99_presented", int'(ok), 1);
        check("t4_p2_stalled", int'(v_ready[2]), 0);
        wait_valid("t4_n0_valid");
        check("t4_n0_spike", int'(out_spike), 0);
        check("t4_n0_mem", int'(out_mem), 62);
        wait_valid("t4_n1_valid");
        check("t4_n1_spike", int'(out_spike), 1);
        check("t4_n1_mem", int'(out_mem), 0);

        // Test 5: downstream backpressure, plus a start that must be ignored
        @(posedge clk);
        #1 out_rdy = 1'b0;
        push_neuron(50, 10, 2, 1, 0, 1, 0, 2);
        wait_valid("t5_valid");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_hold_valid", int'(out_valid), 1);
            check("t5_hold_mem", int'(out_mem), 63);
            check("t5_hold_idx", int'(out_idx), 2);
            check("t5_hold_ready", int'(v_ready), 0);
        end
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        out_rdy = 1'b1;

        // Remainder of the 3x10 run
        for (int n = 6; n < NN * NT; n++) begin
            push_neuron((n * 13) % 40, (n * 7) % 30, (n * 5) % 20, n % 9,
                        n % 3, (n + 1) % 3, (n + 2) % 3, n % 2);
        end
        ok = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done) begin
                ok = 1;
                break;
            end
        end
        check("t5_run_done", int'(ok), 1);
        check("t5_timestep", int'(timestep), 9);
        check("t5_ts_done_pulses", tsd_cnt, 10);
        check("t5_busy", int'(busy), 0);
        check("t5_all_retired", expq.size(), 0);

        // Test 6: asynchronous reset with two operands already held
        push_ch(3, 200, 0);
        push_ch(0, 100, 0);
        do_start();
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (acc[3] > r && acc[0] > r) begin
                ok = 1;
                break;
            end
        end
        check("t6_two_held", int'(ok), 1);
        @(posedge clk);
        #1 chk_en = 0;
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_ready", int'(v_ready), 0);
        check("t6_rst_done", int'(done), 0);
        check("t6_rst_timestep", int'(timestep), 0);
        check("t6_rst_valid", int'(out_valid), 0);
        for (int c = 0; c < 4; c++) acc[c] = 0;
        r          = 0;
        rr_run     = 0;
        run_active = 0;
        done_m     = 0;
        exp_ts     = 0;
        exp_tsd    = 0;
        expq.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1;
        push_n = 0;
        push_neuron(5, 6, 7, 8, 0, 0, 0, 0);
        do_start();
        wait_valid("t6_valid");
        check("t6_spike", int'(out_spike), 0);
        check("t6_mem", int'(out_mem), 26);
        check("t6_idx", int'(out_idx), 0);
        repeat (5) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
